// File: rtl/change_dispenser_if.sv
// Credit-in / coin-out handshake bundle between the credit path, the dispenser and the hopper.
// The master side drives START/CREDIT/COIN_ACK; the dispenser takes the slave side.
interface change_dispenser_if #(
  parameter int CREDIT_W = 4
);
  logic                START;
  logic [CREDIT_W-1:0] CREDIT;
  logic [1:0]          COIN_OUT;
  logic                COIN_VALID;
  logic                COIN_ACK;
  logic [CREDIT_W-1:0] REMAIN;
  logic                BUSY;
  logic                DONE;

  modport master (
    output START, CREDIT, COIN_ACK,
    input  COIN_OUT, COIN_VALID, REMAIN, BUSY, DONE
  );

  modport slave (
    input  START, CREDIT, COIN_ACK,
    output COIN_OUT, COIN_VALID, REMAIN, BUSY, DONE
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays out captured credit as quarters/dimes/nickels, one coin per COIN_VALID/COIN_ACK handshake.
// START to first coin: 1 cycle; last ACK to DONE: 1 cycle; a coin is held until the hopper acks it.
module change_dispenser #(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 12,
  parameter int GAP_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST,
  change_dispenser_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] remain_q, remain_d;
  logic [3:0]          gap_q, gap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          coin_sel;
  logic [CREDIT_W-1:0] coin_units;
  logic [CREDIT_W-1:0] credit_sat;

  // Greedy pick: quarter = 5 units, dime = 2, nickel = 1; never exceeds remain_q when remain_q > 0.
  always_comb begin
    coin_sel   = 2'b01;
    coin_units = CREDIT_W'(1);
    if (remain_q >= CREDIT_W'(5)) begin
      coin_sel   = 2'b11;
      coin_units = CREDIT_W'(5);
    end else if (remain_q >= CREDIT_W'(2)) begin
      coin_sel   = 2'b10;
      coin_units = CREDIT_W'(2);
    end
    credit_sat = (bus.CREDIT > CREDIT_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT) : bus.CREDIT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    gap_d    = gap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          remain_d = credit_sat;
          state_d  = (credit_sat == '0) ? S_FINISH : S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.COIN_ACK) begin
          remain_d = remain_q - coin_units;
          if (remain_d == '0) begin
            state_d = S_FINISH;
          end else if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_PRESENT;
        else               gap_d   = gap_q - 4'd1;
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        remain_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // Coin outputs decode straight from registered state so they only move at the clock edge.
  always_comb begin
    bus.COIN_VALID = (state_q == S_PRESENT);
    bus.COIN_OUT   = (state_q == S_PRESENT) ? coin_sel : 2'b00;
    bus.REMAIN     = remain_q;
    bus.BUSY       = busy_q;
    bus.DONE       = done_q;
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: default build (gap 2) plus a gap-0 build on a second interface.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  change_dispenser_if #(.CREDIT_W(4)) if0 ();
  change_dispenser_if #(.CREDIT_W(4)) if1 ();

  change_dispenser #(.CREDIT_W(4), .MAX_CREDIT(12), .GAP_CYCLES(2)) u_dut (
    .CLK(clk), .RST(rst), .bus(if0.slave));
  change_dispenser #(.CREDIT_W(4), .MAX_CREDIT(12), .GAP_CYCLES(0)) u_dut0 (
    .CLK(clk), .RST(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  int cap_coin[$];
  int cap_rem[$];
  int cap_gap[$];
  int cap_vlen[$];
  int cap_done, cap_done_cyc, cap_first, cap_r0, cap_busy_after;
  bit cap_stable, cap_timeout;

  // Runs one payout on if0, acting as the hopper. ack_delay < 0 holds ACK high throughout;
  // otherwise ACK rises after the coin has been valid for ack_delay cycles.
  task automatic drive_payout(input logic [3:0] credit, input int ack_delay);
    int   vcount, lowrun;
    logic prev_ack;
    int   cur;
    cap_coin.delete(); cap_rem.delete(); cap_gap.delete(); cap_vlen.delete();
    cap_done = 0; cap_done_cyc = -1; cap_first = -1; cap_busy_after = -1;
    cap_stable = 1'b1; cap_timeout = 1'b1; cur = 0;
    if0.CREDIT = credit; if0.START = 1'b1; if0.COIN_ACK = (ack_delay < 0);
    @(posedge clk); #1;
    if0.START = 1'b0;
    cap_r0 = int'(if0.REMAIN);
    vcount = 0; lowrun = 0; prev_ack = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (prev_ack) cap_rem.push_back(int'(if0.REMAIN));
      prev_ack = 1'b0;
      if (if0.COIN_VALID) begin
        if (vcount == 0) begin
          if (cap_coin.size() > 0) cap_gap.push_back(lowrun);
          cur = int'(if0.COIN_OUT);
          cap_coin.push_back(cur);
          if (cap_first < 0) cap_first = cyc;
        end else if (int'(if0.COIN_OUT) != cur) cap_stable = 1'b0;
        vcount++;
        lowrun = 0;
        if (ack_delay >= 0) if0.COIN_ACK = (vcount >= ack_delay + 1);
        prev_ack = if0.COIN_ACK;
      end else begin
        if (vcount > 0) cap_vlen.push_back(vcount);
        vcount = 0;
        lowrun++;
        if (ack_delay >= 0) if0.COIN_ACK = 1'b0;
        if (if0.COIN_OUT !== 2'b00) cap_stable = 1'b0;
      end
      if (if0.DONE === 1'b1) begin
        cap_done++;
        if (cap_done_cyc < 0) cap_done_cyc = cyc;
      end else if (cap_done > 0) begin
        cap_busy_after = int'(if0.BUSY);
        cap_timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if0.COIN_ACK = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (if0.BUSY !== 1'b0 || if0.DONE !== 1'b0 || if0.COIN_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b valid=%b expected 0 0 0", if0.BUSY, if0.DONE, if0.COIN_VALID); end
    checks++; if (if0.REMAIN !== 4'd0 || if0.COIN_OUT !== 2'b00) begin
      errors++; $display("FAIL reset_data: got remain=%0d coin=%b expected 0 00", if0.REMAIN, if0.COIN_OUT); end
    checks++; if (if1.BUSY !== 1'b0 || if1.REMAIN !== 4'd0 || if1.COIN_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_gap0: got busy=%b remain=%0d valid=%b expected 0 0 0", if1.BUSY, if1.REMAIN, if1.COIN_VALID); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_full_payout(input logic [3:0] credit, input string tag);
    int exp_c[3] = '{3, 3, 2};
    int exp_r[3] = '{7, 2, 0};
    drive_payout(credit, 1);
    checks++; if (cap_timeout) begin errors++; $display("FAIL %s_timeout: got no DONE expected DONE", tag); end
    checks++; if (cap_r0 != 12) begin errors++; $display("FAIL %s_remain0: got %0d expected 12", tag, cap_r0); end
    checks++; if (cap_first != 1) begin errors++; $display("FAIL %s_first_valid: got cycle %0d expected 1", tag, cap_first); end
    checks++; if (cap_coin.size() != 3) begin
      errors++; $display("FAIL %s_ncoins: got %0d expected 3", tag, cap_coin.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (cap_coin[i] != exp_c[i]) begin errors++; $display("FAIL %s_coin%0d: got %0d expected %0d", tag, i, cap_coin[i], exp_c[i]); end
      checks++; if (cap_rem[i] != exp_r[i]) begin errors++; $display("FAIL %s_remain%0d: got %0d expected %0d", tag, i, cap_rem[i], exp_r[i]); end
    end
    checks++; if (cap_gap.size() != 2 || cap_gap[0] != 2 || cap_gap[1] != 2) begin
      errors++; $display("FAIL %s_gaps: got %p expected 2,2", tag, cap_gap); end
    checks++; if (cap_done != 1 || cap_done_cyc != 11) begin
      errors++; $display("FAIL %s_done: got %0d pulses at cycle %0d expected 1 at 11", tag, cap_done, cap_done_cyc); end
    checks++; if (cap_busy_after != 0) begin errors++; $display("FAIL %s_busy_drop: got %0d expected 0", tag, cap_busy_after); end
    checks++; if (!cap_stable) begin errors++; $display("FAIL %s_coin_stable: got unstable expected stable", tag); end
  endtask

  task automatic test_greedy_mix();
    int exp_c[3] = '{3, 2, 2};
    int exp_r[3] = '{4, 2, 0};
    drive_payout(4'd9, -1);
    checks++; if (cap_timeout) begin errors++; $display("FAIL mix_timeout: got no DONE expected DONE"); end
    checks++; if (cap_coin.size() != 3 || cap_vlen.size() != 3) begin
      errors++; $display("FAIL mix_ncoins: got %0d coins %0d vlens expected 3 3", cap_coin.size(), cap_vlen.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (cap_coin[i] != exp_c[i]) begin errors++; $display("FAIL mix_coin%0d: got %0d expected %0d", i, cap_coin[i], exp_c[i]); end
      checks++; if (cap_rem[i] != exp_r[i]) begin errors++; $display("FAIL mix_remain%0d: got %0d expected %0d", i, cap_rem[i], exp_r[i]); end
      checks++; if (cap_vlen[i] != 1) begin errors++; $display("FAIL mix_vlen%0d: got %0d expected 1", i, cap_vlen[i]); end
    end
    checks++; if (cap_done != 1 || cap_done_cyc != 8) begin
      errors++; $display("FAIL mix_done: got %0d pulses at cycle %0d expected 1 at 8", cap_done, cap_done_cyc); end
  endtask

  task automatic test_stall();
    drive_payout(4'd1, 10);
    checks++; if (cap_coin.size() != 1 || cap_coin[0] != 1) begin
      errors++; $display("FAIL stall_coin: got %p expected 1", cap_coin); end
    checks++; if (cap_vlen.size() != 1 || cap_vlen[0] != 11 || !cap_stable) begin
      errors++; $display("FAIL stall_hold: got vlen %p stable=%0d expected 11 stable=1", cap_vlen, cap_stable); end
    checks++; if (cap_rem.size() != 1 || cap_rem[0] != 0) begin
      errors++; $display("FAIL stall_remain: got %p expected 0", cap_rem); end
    checks++; if (cap_done != 1 || cap_done_cyc != 12) begin
      errors++; $display("FAIL stall_done: got %0d pulses at cycle %0d expected 1 at 12", cap_done, cap_done_cyc); end
  endtask

  task automatic test_zero_credit();
    drive_payout(4'd0, 1);
    checks++; if (cap_coin.size() != 0) begin errors++; $display("FAIL zero_no_coin: got %0d coins expected 0", cap_coin.size()); end
    checks++; if (cap_done != 1 || cap_done_cyc != 1) begin
      errors++; $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at 1", cap_done, cap_done_cyc); end
    checks++; if (cap_busy_after != 0) begin errors++; $display("FAIL zero_busy_drop: got %0d expected 0", cap_busy_after); end
  endtask

  task automatic test_ignored_start();
    if0.CREDIT = 4'd5; if0.START = 1'b1; if0.COIN_ACK = 1'b0;
    @(posedge clk); #1;
    if0.CREDIT = 4'd12;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (if0.REMAIN !== 4'd5 || if0.COIN_OUT !== 2'b11 || if0.COIN_VALID !== 1'b1) begin
      errors++; $display("FAIL ign_start_busy: got remain=%0d coin=%b valid=%b expected 5 11 1", if0.REMAIN, if0.COIN_OUT, if0.COIN_VALID); end
    if0.START = 1'b0; if0.COIN_ACK = 1'b1;
    @(posedge clk); #1;
    if0.COIN_ACK = 1'b0;
    checks++; if (if0.DONE !== 1'b1 || if0.REMAIN !== 4'd0 || if0.BUSY !== 1'b1) begin
      errors++; $display("FAIL ign_finish: got done=%b remain=%0d busy=%b expected 1 0 1", if0.DONE, if0.REMAIN, if0.BUSY); end
    if0.START = 1'b1; if0.CREDIT = 4'd7;
    @(posedge clk); #1;
    if0.START = 1'b0;
    checks++; if (if0.BUSY !== 1'b0 || if0.REMAIN !== 4'd0 || if0.DONE !== 1'b0) begin
      errors++; $display("FAIL ign_start_finish: got busy=%b remain=%0d done=%b expected 0 0 0", if0.BUSY, if0.REMAIN, if0.DONE); end
  endtask

  task automatic test_reset_mid_present();
    if0.CREDIT = 4'd12; if0.START = 1'b1; if0.COIN_ACK = 1'b0;
    @(posedge clk); #1;
    if0.START = 1'b0;
    checks++; if (if0.COIN_VALID !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", if0.COIN_VALID); end
    #2 rst = 1'b1;
    #1;
    checks++; if (if0.COIN_VALID !== 1'b0 || if0.COIN_OUT !== 2'b00 || if0.REMAIN !== 4'd0 || if0.BUSY !== 1'b0 || if0.DONE !== 1'b0) begin
      errors++; $display("FAIL rst_async: got valid=%b coin=%b remain=%0d busy=%b done=%b expected 0 00 0 0 0",
                         if0.COIN_VALID, if0.COIN_OUT, if0.REMAIN, if0.BUSY, if0.DONE); end
    @(posedge clk); #1 rst = 1'b0;
    drive_payout(4'd2, 1);
    checks++; if (cap_coin.size() != 1 || cap_coin[0] != 2 || cap_rem.size() != 1 || cap_rem[0] != 0) begin
      errors++; $display("FAIL rst_then_dime: got coins %p remain %p expected 2 and 0", cap_coin, cap_rem); end
    checks++; if (cap_done != 1) begin errors++; $display("FAIL rst_then_done: got %0d pulses expected 1", cap_done); end
  endtask

  task automatic test_back_to_back();
    int exp_v[5] = '{1, 1, 1, 0, 0};
    int exp_c[5] = '{3, 3, 2, 0, 0};
    int exp_r[5] = '{12, 7, 2, 0, 0};
    int exp_d[5] = '{0, 0, 0, 1, 0};
    int exp_b[5] = '{1, 1, 1, 1, 0};
    if1.CREDIT = 4'd12; if1.START = 1'b1; if1.COIN_ACK = 1'b1;
    @(posedge clk); #1;
    if1.START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int'(if1.COIN_VALID) != exp_v[i] || int'(if1.COIN_OUT) != exp_c[i] || int'(if1.REMAIN) != exp_r[i] ||
          int'(if1.DONE) != exp_d[i] || int'(if1.BUSY) != exp_b[i]) begin
        errors++;
        $display("FAIL gap0_cyc%0d: got valid=%b coin=%b remain=%0d done=%b busy=%b expected %0d %0d %0d %0d %0d", i + 1,
                 if1.COIN_VALID, if1.COIN_OUT, if1.REMAIN, if1.DONE, if1.BUSY, exp_v[i], exp_c[i], exp_r[i], exp_d[i], exp_b[i]);
      end
      @(posedge clk); #1;
    end
    if1.COIN_ACK = 1'b0;
  endtask

  initial begin
    if0.START = 1'b0; if0.CREDIT = '0; if0.COIN_ACK = 1'b0;
    if1.START = 1'b0; if1.CREDIT = '0; if1.COIN_ACK = 1'b0;
    test_reset();
    test_full_payout(4'd12, "full");
    test_greedy_mix();
    test_stall();
    test_zero_credit();
    test_full_payout(4'd15, "sat");
    test_ignored_start();
    test_reset_mid_present();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
